// File: rtl/arbitro_pkg.sv
// Shared types and constants for the memory arbiter slice.
package arbitro_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ACESSO   = 2'd1,
    RESPOSTA = 2'd2
  } estado_t;

  typedef enum logic {
    BUSCA = 1'b0,
    DADO  = 1'b1
  } requisitante_t;

  localparam int unsigned TIMEOUT_PADRAO = 15;
  localparam int unsigned LARGURA_PADRAO = 32;

  // A fetch returning this word marks the end of the program.
  localparam logic [LARGURA_PADRAO-1:0] PALAVRA_ZERO = '0;

endpackage

// File: rtl/arbitro_memoria_if.sv
// Fetch, load/store and memory-port signals of the arbiter.
interface arbitro_memoria_if #(
  parameter int unsigned LARGURA_DADOS = 32,
  parameter int unsigned LARGURA_END   = 32
);

  logic                     busca_req;
  logic [LARGURA_END-1:0]   busca_end;
  logic                     busca_pronto;
  logic [LARGURA_DADOS-1:0] busca_instrucao;

  logic                     dado_req;
  logic                     dado_escrita;
  logic [LARGURA_END-1:0]   dado_end;
  logic [LARGURA_DADOS-1:0] dado_wdata;
  logic                     dado_pronto;
  logic [LARGURA_DADOS-1:0] dado_rdata;

  logic                     mem_req;
  logic                     mem_escrita;
  logic [LARGURA_END-1:0]   mem_end;
  logic [LARGURA_DADOS-1:0] mem_wdata;
  logic                     mem_pronto;
  logic [LARGURA_DADOS-1:0] mem_rdata;

  logic                     erro;
  logic                     fim_programa;

  // Arbiter side.
  modport master (
    input  busca_req, busca_end, dado_req, dado_escrita, dado_end, dado_wdata,
           mem_pronto, mem_rdata,
    output busca_pronto, busca_instrucao, dado_pronto, dado_rdata,
           mem_req, mem_escrita, mem_end, mem_wdata, erro, fim_programa
  );

  // Requesters and memory side.
  modport slave (
    output busca_req, busca_end, dado_req, dado_escrita, dado_end, dado_wdata,
           mem_pronto, mem_rdata,
    input  busca_pronto, busca_instrucao, dado_pronto, dado_rdata,
           mem_req, mem_escrita, mem_end, mem_wdata, erro, fim_programa
  );

endinterface

// File: rtl/contador_timeout.sv
// Counts cycles of an in-flight access and flags the last allowed cycle.
module contador_timeout
  import arbitro_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_PADRAO
) (
  input  logic clock,
  input  logic reset_n,
  input  logic habilita,
  input  logic limpa,
  output logic estourou
);

  localparam int unsigned LARGURA_CONT = $clog2(TIMEOUT + 1);

  logic [LARGURA_CONT-1:0] r_cont;

  // Cycle counter: clear has priority over count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cont <= '0;
    end else if (limpa) begin
      r_cont <= '0;
    end else if (habilita) begin
      r_cont <= r_cont + LARGURA_CONT'(1);
    end
  end

  // High in the cycle whose increment makes the count reach TIMEOUT.
  assign estourou = habilita && (r_cont == LARGURA_CONT'(TIMEOUT - 1));

endmodule

// File: rtl/arbitro_memoria.sv
// Round-robin arbiter/sequencer of fetch and load/store onto one memory port.
module arbitro_memoria
  import arbitro_pkg::*;
#(
  parameter int unsigned LARGURA_DADOS = 32,
  parameter int unsigned LARGURA_END   = 32,
  parameter int unsigned TIMEOUT       = TIMEOUT_PADRAO
) (
  input  logic             clock,
  input  logic             reset_n,
  arbitro_memoria_if.master bus
);

  estado_t                  r_estado,        w_prox_estado;
  requisitante_t            r_ultimo,        w_prox_ultimo;
  requisitante_t            r_dono,          w_prox_dono;
  logic                     r_mem_req,       w_prox_mem_req;
  logic                     r_mem_escrita,   w_prox_mem_escrita;
  logic [LARGURA_END-1:0]   r_mem_end,       w_prox_mem_end;
  logic [LARGURA_DADOS-1:0] r_mem_wdata,     w_prox_mem_wdata;
  logic                     r_busca_pronto,  w_prox_busca_pronto;
  logic [LARGURA_DADOS-1:0] r_busca_instr,   w_prox_busca_instr;
  logic                     r_dado_pronto,   w_prox_dado_pronto;
  logic [LARGURA_DADOS-1:0] r_dado_rdata,    w_prox_dado_rdata;
  logic                     r_erro,          w_prox_erro;
  logic                     r_fim,           w_prox_fim;

  requisitante_t            w_vencedor;
  logic [LARGURA_DADOS-1:0] w_palavra;
  logic                     w_busca_eleg;
  logic                     w_dado_eleg;
  logic                     w_concluiu;
  logic                     w_habilita;
  logic                     w_limpa;
  logic                     w_estourou;

  contador_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_contador (
    .clock    (clock),
    .reset_n  (reset_n),
    .habilita (w_habilita),
    .limpa    (w_limpa),
    .estourou (w_estourou)
  );

  // Fetches stop being eligible once the end of program is seen.
  assign w_busca_eleg = bus.busca_req && !r_fim;
  assign w_dado_eleg  = bus.dado_req;

  // Next-state, arbitration, latching and completion logic.
  always_comb begin
    w_prox_estado       = r_estado;
    w_prox_ultimo       = r_ultimo;
    w_prox_dono         = r_dono;
    w_prox_mem_req      = r_mem_req;
    w_prox_mem_escrita  = r_mem_escrita;
    w_prox_mem_end      = r_mem_end;
    w_prox_mem_wdata    = r_mem_wdata;
    w_prox_busca_pronto = 1'b0;
    w_prox_busca_instr  = r_busca_instr;
    w_prox_dado_pronto  = 1'b0;
    w_prox_dado_rdata   = r_dado_rdata;
    w_prox_erro         = r_erro;
    w_prox_fim          = r_fim;
    w_vencedor          = r_dono;
    w_palavra           = '0;
    w_concluiu          = 1'b0;
    w_habilita          = 1'b0;
    w_limpa             = 1'b0;

    case (r_estado)
      OCIOSO: begin
        if (w_busca_eleg || w_dado_eleg) begin
          if (w_busca_eleg && w_dado_eleg) begin
            w_vencedor = (r_ultimo == BUSCA) ? DADO : BUSCA;
          end else if (w_dado_eleg) begin
            w_vencedor = DADO;
          end else begin
            w_vencedor = BUSCA;
          end
          w_prox_dono    = w_vencedor;
          w_prox_mem_req = 1'b1;
          w_prox_estado  = ACESSO;
          if (w_vencedor == DADO) begin
            w_prox_mem_end     = bus.dado_end;
            w_prox_mem_escrita = bus.dado_escrita;
            w_prox_mem_wdata   = bus.dado_escrita ? bus.dado_wdata : '0;
          end else begin
            w_prox_mem_end     = bus.busca_end;
            w_prox_mem_escrita = 1'b0;
            w_prox_mem_wdata   = '0;
          end
        end
      end

      ACESSO: begin
        w_habilita = 1'b1;
        // A real completion outranks a coinciding timeout.
        if (bus.mem_pronto) begin
          w_concluiu = 1'b1;
          w_palavra  = r_mem_escrita ? '0 : bus.mem_rdata;
        end else if (w_estourou) begin
          w_concluiu  = 1'b1;
          w_prox_erro = 1'b1;
        end
        if (w_concluiu) begin
          w_prox_estado      = RESPOSTA;
          w_prox_mem_req     = 1'b0;
          w_prox_mem_escrita = 1'b0;
          if (r_dono == BUSCA) begin
            w_prox_busca_pronto = 1'b1;
            w_prox_busca_instr  = w_palavra;
            if (w_palavra == LARGURA_DADOS'(PALAVRA_ZERO)) begin
              w_prox_fim = 1'b1;
            end
          end else begin
            w_prox_dado_pronto = 1'b1;
            w_prox_dado_rdata  = w_palavra;
          end
        end
      end

      RESPOSTA: begin
        w_limpa       = 1'b1;
        w_prox_ultimo = r_dono;
        w_prox_estado = OCIOSO;
      end

      default: begin
        w_prox_estado  = OCIOSO;
        w_prox_mem_req = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight access.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado       <= OCIOSO;
      r_ultimo       <= BUSCA;
      r_dono         <= BUSCA;
      r_mem_req      <= 1'b0;
      r_mem_escrita  <= 1'b0;
      r_mem_end      <= '0;
      r_mem_wdata    <= '0;
      r_busca_pronto <= 1'b0;
      r_busca_instr  <= '0;
      r_dado_pronto  <= 1'b0;
      r_dado_rdata   <= '0;
      r_erro         <= 1'b0;
      r_fim          <= 1'b0;
    end else begin
      r_estado       <= w_prox_estado;
      r_ultimo       <= w_prox_ultimo;
      r_dono         <= w_prox_dono;
      r_mem_req      <= w_prox_mem_req;
      r_mem_escrita  <= w_prox_mem_escrita;
      r_mem_end      <= w_prox_mem_end;
      r_mem_wdata    <= w_prox_mem_wdata;
      r_busca_pronto <= w_prox_busca_pronto;
      r_busca_instr  <= w_prox_busca_instr;
      r_dado_pronto  <= w_prox_dado_pronto;
      r_dado_rdata   <= w_prox_dado_rdata;
      r_erro         <= w_prox_erro;
      r_fim          <= w_prox_fim;
    end
  end

  assign bus.mem_req         = r_mem_req;
  assign bus.mem_escrita     = r_mem_escrita;
  assign bus.mem_end         = r_mem_end;
  assign bus.mem_wdata       = r_mem_wdata;
  assign bus.busca_pronto    = r_busca_pronto;
  assign bus.busca_instrucao = r_busca_instr;
  assign bus.dado_pronto     = r_dado_pronto;
  assign bus.dado_rdata      = r_dado_rdata;
  assign bus.erro            = r_erro;
  assign bus.fim_programa    = r_fim;

endmodule

// File: tb/tb_arbitro_memoria.sv
// Directed bench for arbitro_memoria with a transaction scoreboard.
module tb_arbitro_memoria;

  localparam int unsigned TO = 4;

  logic clock;
  logic reset_n;

  arbitro_memoria_if bus ();

  arbitro_memoria #(
    .LARGURA_DADOS (32),
    .LARGURA_END   (32),
    .TIMEOUT       (TO)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    bit          busca;
    logic [31:0] ender;
    bit          escrita;
    logic [31:0] wdata;
    logic [31:0] palavra;
  } trans_t;

  trans_t sb[$];
  trans_t t_mon;

  int n_checks = 0;
  int n_errors = 0;

  int mem_espera = 0;
  int mem_ciclos = 0;
  bit mem_nunca  = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory contents seen by the bench.
  function automatic logic [31:0] conteudo(input logic [31:0] a);
    if (a == 32'd8)        return 32'h2002000A;
    else if (a == 32'h100) return 32'h0;
    else                   return {16'hC0DE, a[15:0]};
  endfunction

  task automatic push(input bit b, input logic [31:0] e, input bit w,
                      input logic [31:0] wd, input logic [31:0] p);
    trans_t t;
    t.busca = b; t.ender = e; t.escrita = w; t.wdata = wd; t.palavra = p;
    sb.push_back(t);
  endtask

  task automatic espera_pronto(input int limite, output int lat);
    lat = 0;
    for (int i = 0; i < limite; i++) begin
      @(negedge clock);
      lat++;
      if (bus.busca_pronto || bus.dado_pronto) return;
    end
    chk("espera_pronto", 64'(bus.busca_pronto | bus.dado_pronto), 64'd1);
  endtask

  // Memory model: checks the latched access and answers after mem_espera waits.
  always @(negedge clock) begin
    if (bus.mem_req) begin
      if (sb.size() == 0) begin
        chk("mem_req_inesperado", 64'(bus.mem_req), 64'd0);
      end else begin
        chk("mem_end", 64'(bus.mem_end), 64'(sb[0].ender));
        chk("mem_escrita", 64'(bus.mem_escrita), 64'(sb[0].escrita));
        chk("mem_wdata", 64'(bus.mem_wdata), 64'(sb[0].escrita ? sb[0].wdata : 32'h0));
      end
      if (!mem_nunca && mem_ciclos == mem_espera) begin
        bus.mem_pronto = 1'b1;
        bus.mem_rdata  = conteudo(bus.mem_end);
      end else begin
        bus.mem_pronto = 1'b0;
        bus.mem_rdata  = 32'hBAD0BAD0;
      end
      mem_ciclos++;
    end else begin
      mem_ciclos     = 0;
      bus.mem_pronto = 1'b0;
      bus.mem_rdata  = 32'hBAD0BAD0;
    end
  end

  // Completion monitor: pops the scoreboard on every pronto.
  always @(negedge clock) begin
    if (reset_n && (bus.busca_pronto || bus.dado_pronto)) begin
      if (sb.size() == 0) begin
        chk("pronto_inesperado", 64'({bus.busca_pronto, bus.dado_pronto}), 64'd0);
      end else begin
        t_mon = sb.pop_front();
        chk("requisitante", 64'({bus.busca_pronto, bus.dado_pronto}),
            64'(t_mon.busca ? 2'b10 : 2'b01));
        if (t_mon.busca) chk("busca_instrucao", 64'(bus.busca_instrucao), 64'(t_mon.palavra));
        else             chk("dado_rdata", 64'(bus.dado_rdata), 64'(t_mon.palavra));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n_p;
    bit prev;
    bit cur;
    bit vista;

    reset_n          = 1'b0;
    bus.busca_req    = 1'b0;
    bus.busca_end    = '0;
    bus.dado_req     = 1'b0;
    bus.dado_escrita = 1'b0;
    bus.dado_end     = '0;
    bus.dado_wdata   = '0;
    repeat (3) @(negedge clock);

    // Reset values
    chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst_prontos", 64'({bus.busca_pronto, bus.dado_pronto}), 64'd0);
    chk("rst_flags", 64'({bus.erro, bus.fim_programa}), 64'd0);
    chk("rst_mem_end", 64'(bus.mem_end), 64'd0);
    chk("rst_busca_instrucao", 64'(bus.busca_instrucao), 64'd0);
    reset_n = 1'b1;

    // Single fetch, zero wait states
    @(negedge clock);
    mem_espera = 0;
    push(1'b1, 32'd8, 1'b0, 32'h0, 32'h2002000A);
    bus.busca_end = 32'd8;
    bus.busca_req = 1'b1;
    espera_pronto(10, lat);
    bus.busca_req = 1'b0;
    chk("busca_latencia", 64'(lat), 64'd2);
    @(negedge clock);
    chk("busca_pulso", 64'(bus.busca_pronto), 64'd0);
    chk("busca_instr_mantida", 64'(bus.busca_instrucao), 64'h2002000A);

    // Store with two wait states
    mem_espera = 2;
    push(1'b0, 32'd16, 1'b1, 32'hDEADBEEF, 32'h0);
    bus.dado_escrita = 1'b1;
    bus.dado_end     = 32'd16;
    bus.dado_wdata   = 32'hDEADBEEF;
    bus.dado_req     = 1'b1;
    espera_pronto(12, lat);
    bus.dado_req     = 1'b0;
    bus.dado_escrita = 1'b0;
    chk("store_latencia", 64'(lat), 64'd4);

    // Contention from reset, one wait state: dado, busca, dado, busca
    @(negedge clock);
    reset_n = 1'b0;
    sb.delete();
    mem_espera    = 1;
    bus.busca_end = 32'h20;
    bus.dado_end  = 32'h40;
    bus.busca_req = 1'b1;
    bus.dado_req  = 1'b1;
    push(1'b0, 32'h40, 1'b0, 32'h0, conteudo(32'h40));
    push(1'b1, 32'h20, 1'b0, 32'h0, conteudo(32'h20));
    push(1'b0, 32'h40, 1'b0, 32'h0, conteudo(32'h40));
    push(1'b1, 32'h20, 1'b0, 32'h0, conteudo(32'h20));
    @(negedge clock);
    reset_n = 1'b1;
    prev = 1'b0;
    n_p  = 0;
    for (int i = 0; i < 60 && n_p < 4; i++) begin
      @(negedge clock);
      cur = bus.busca_pronto | bus.dado_pronto;
      if (cur) begin
        chk("pronto_um_ciclo", 64'(prev), 64'd0);
        n_p++;
      end
      prev = cur;
    end
    bus.busca_req = 1'b0;
    bus.dado_req  = 1'b0;
    chk("n_concessoes", 64'(n_p), 64'd4);

    // Completion coinciding with the timeout cycle
    @(negedge clock);
    mem_espera = TO - 1;
    push(1'b1, 32'h30, 1'b0, 32'h0, conteudo(32'h30));
    bus.busca_end = 32'h30;
    bus.busca_req = 1'b1;
    espera_pronto(20, lat);
    bus.busca_req = 1'b0;
    chk("coincid_latencia", 64'(lat), 64'(TO + 1));
    chk("coincid_erro", 64'(bus.erro), 64'd0);

    // Asynchronous reset during an access
    @(negedge clock);
    mem_nunca = 1'b1;
    push(1'b0, 32'h50, 1'b0, 32'h0, conteudo(32'h50));
    bus.dado_end = 32'h50;
    bus.dado_req = 1'b1;
    @(negedge clock);
    chk("mem_req_em_acesso", 64'(bus.mem_req), 64'd1);
    #2 reset_n = 1'b0;
    #1 chk("mem_req_reset_async", 64'(bus.mem_req), 64'd0);
    bus.dado_req = 1'b0;
    sb.delete();
    vista = 1'b0;
    repeat (3) begin
      @(negedge clock);
      vista = vista | bus.busca_pronto | bus.dado_pronto;
    end
    chk("sem_pronto_em_reset", 64'(vista), 64'd0);
    reset_n    = 1'b1;
    mem_nunca  = 1'b0;
    mem_espera = 0;
    @(negedge clock);
    push(1'b0, 32'h50, 1'b0, 32'h0, conteudo(32'h50));
    bus.dado_req = 1'b1;
    espera_pronto(10, lat);
    bus.dado_req = 1'b0;
    chk("pos_reset_latencia", 64'(lat), 64'd2);

    // Fetch timeout: zero word, erro and end of program
    @(negedge clock);
    mem_nunca = 1'b1;
    push(1'b1, 32'h60, 1'b0, 32'h0, 32'h0);
    bus.busca_end = 32'h60;
    bus.busca_req = 1'b1;
    espera_pronto(20, lat);
    bus.busca_req = 1'b0;
    chk("timeout_latencia", 64'(lat), 64'(TO + 1));
    chk("timeout_erro", 64'(bus.erro), 64'd1);
    chk("timeout_fim", 64'(bus.fim_programa), 64'd1);

    // After end of program only data is served
    @(negedge clock);
    mem_nunca = 1'b0;
    push(1'b0, 32'h70, 1'b0, 32'h0, conteudo(32'h70));
    bus.dado_end  = 32'h70;
    bus.busca_req = 1'b1;
    bus.dado_req  = 1'b1;
    espera_pronto(10, lat);
    bus.dado_req  = 1'b0;
    chk("dado_apos_fim_latencia", 64'(lat), 64'd2);
    vista = 1'b0;
    repeat (8) begin
      @(negedge clock);
      vista = vista | bus.mem_req;
    end
    bus.busca_req = 1'b0;
    chk("busca_ignorada", 64'(vista), 64'd0);
    chk("erro_persistente", 64'(bus.erro), 64'd1);

    // Reset clears the sticky flags
    reset_n = 1'b0;
    #1;
    chk("reset_limpa_flags", 64'({bus.erro, bus.fim_programa}), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/arbitro_memoria.md
# arbitro_memoria

Two-requester arbiter and sequencer for the processor's single-ported instruction/data memory. It serializes instruction-fetch and data load/store requests onto one memory port, runs each access as a request/ready transaction, and aborts accesses the memory fails to complete. It sits between the fetch stage, the load/store stage and the memory model. It also raises the end-of-program flag when a fetch returns an all-zero word.

## Interface
- LARGURA_DADOS, 32, data and instruction word width
- LARGURA_END, 32, address width
- TIMEOUT, 15, maximum cycles in ACESSO before the access is aborted; minimum 1

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  reset; asynchronous and active-low
- busca_req  in  1  fetch request, held until busca_pronto
- busca_end  in  LARGURA_END  fetch address, stable while busca_req=1
- busca_pronto  out  1  one-cycle fetch-complete pulse
- busca_instrucao  out  LARGURA_DADOS  fetched word, valid with busca_pronto and held until the next fetch completes
- dado_req  in  1  data request, held until dado_pronto
- dado_escrita  in  1  1 = store, 0 = load
- dado_end  in  LARGURA_END  data address
- dado_wdata  in  LARGURA_DADOS  store data
- dado_pronto  out  1  one-cycle data-complete pulse
- dado_rdata  out  LARGURA_DADOS  load result; 0 on store completion
- mem_req  out  1  memory access active
- mem_escrita  out  1  write strobe qualifier
- mem_end  out  LARGURA_END  latched address
- mem_wdata  out  LARGURA_DADOS  latched store data; 0 on reads
- mem_pronto  in  1  memory completion, sampled only in ACESSO
- mem_rdata  in  LARGURA_DADOS  read data, valid with mem_pronto
- erro  out  1  sticky; set on any timeout
- fim_programa  out  1  sticky; set when a fetch completes with word 0

## Operation
- Reset values: every output is 0, the state is OCIOSO, the timeout counter is 0, and ultimo is BUSCA.
- FSM states:
  - OCIOSO:
    - The eligible requests are dado_req, and busca_req only while fim_programa=0.
    - With one eligible request, that requester wins.
    - With both eligible, the winner is the requester opposite ultimo (round-robin), so the first tie after reset goes to dado.
    - The winner's address, write data and direction are latched into registers, and the state moves to ACESSO.
    - With no eligible request, the state stays in OCIOSO.
  - ACESSO:
    - mem_req=1 and the latched values are driven onto the mem_* ports.
    - The counter increments every cycle.
    - If mem_pronto=1, mem_rdata is captured (0 for a store) and the state moves to RESPOSTA.
    - Else if the counter equals TIMEOUT, the captured word is 0, erro is set, and the state moves to RESPOSTA.
  - RESPOSTA:
    - mem_req=0.
    - The winner's pronto is 1 for exactly this cycle, and its output word is updated.
    - ultimo takes the winner's value and the counter clears.
    - The state moves to OCIOSO.
- If mem_pronto and the counter reaching TIMEOUT coincide, mem_pronto wins: no error is flagged and the real data is returned.
- A fetch completion whose word is 32'h0 sets fim_programa. This applies to a genuine zero read and to a timeout.
- Once fim_programa=1, busca_req is ignored permanently and data accesses continue to be served.
- A request still asserted in the cycle after its pronto is treated as a new request.
- Requests, addresses and data are never combinationally forwarded to the memory port.
- Asynchronous reset during an access:
  - The state returns to OCIOSO immediately and mem_req drops in the same cycle.
  - No pronto is issued and the in-flight access is discarded.
  - erro and fim_programa clear.

## Timing
- All outputs are registered.
- Best-case latency:
  - Cycle 0: the request is sampled in OCIOSO.
  - Cycle 1: mem_req=1; if mem_pronto=1 in this cycle, cycle 2 follows directly.
  - Cycle 2: pronto pulses.
- Each extra memory wait state adds 1 cycle.
- A timed-out access returns pronto TIMEOUT+1 cycles after the request is sampled.
- Back-to-back throughput is one access per 3 cycles minimum.
- With both requesters held continuously, grants strictly alternate.

## Structure
- Shared package arbitro_pkg holds:
  - the state encoding: OCIOSO, ACESSO, RESPOSTA;
  - requester identifiers: BUSCA, DADO;
  - the default TIMEOUT;
  - the zero-word constant used for end-of-program detection.
- Sub-module contador_timeout, parameterized on TIMEOUT, with these ports:
  - inputs: clock, reset_n, habilita, limpa;
  - output: estourou.
- The FSM, arbitration and latching stay in arbitro_memoria.

## Test plan
- Single fetch:
  - Stimulus: busca_req=1, busca_end=8; the memory answers mem_pronto=1 in its first ACESSO cycle with mem_rdata=32'h2002000A.
  - Response: busca_pronto pulses 2 cycles after sampling with busca_instrucao=32'h2002000A; mem_end=8 during ACESSO.
- Contention:
  - Stimulus: busca_req and dado_req held high from reset; the memory takes 1 wait state.
  - Response: grant order is dado, busca, dado, busca; each pronto lasts exactly 1 cycle.
- Store:
  - Stimulus: dado_escrita=1, dado_end=16, dado_wdata=32'hDEADBEEF.
  - Response: mem_escrita=1 and mem_wdata=32'hDEADBEEF throughout ACESSO; dado_pronto with dado_rdata=0.
- Timeout with TIMEOUT=4:
  - Stimulus: mem_pronto never asserted on a fetch.
  - Response: busca_pronto arrives 5 cycles after sampling with word 0; erro=1 and fim_programa=1; later busca_req is never granted while dado_req is still served.
- Coincidence:
  - Stimulus: mem_pronto arrives in the same cycle the counter hits TIMEOUT.
  - Response: data is returned and erro stays 0.
- Reset mid-access:
  - Stimulus: reset_n dropped in ACESSO.
  - Response: mem_req=0 asynchronously; no pronto; after release, a new request completes normally.
